// File: rtl/avalon_sched_pkg.sv
// Shared types and helpers for the Avalon tile scheduler.
// Holds the issue FSM state encoding, a constant clog2 and the tile-size derivation macros.
`ifndef AVALON_SCHED_PKG_SV
`define AVALON_SCHED_PKG_SV

`define AVS_TILE_BYTES(tile_size, dw) ((tile_size) * (dw) / 8)
`define AVS_NUM_TILES(data_size, tile_size) ((data_size) / (tile_size))

package avalon_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ARM   = 2'd2,
        ST_WAIT  = 2'd3
    } tile_st_e;

    // Ceiling log2 for elaboration-time width sizing.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

`endif

// File: rtl/tile_issue_fsm.sv
// Generic issue/arm/wait command FSM for one Avalon master.
// IDLE waits for issue_ok, ISSUE pulses go, ARM masks the master's stale done,
// WAIT returns to IDLE when the master reports done (complete_o flags that cycle).
module tile_issue_fsm
    import avalon_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic issue_ok_i,
    input  logic mst_done_i,
    output logic go_o,
    output logic idle_o,
    output logic complete_o
);

    tile_st_e state_q;
    logic     go_q;

    assign go_o       = go_q;
    assign idle_o     = (state_q == ST_IDLE);
    assign complete_o = (state_q == ST_WAIT) && mst_done_i;

    // State register with go registered alongside the IDLE->ISSUE transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            go_q    <= 1'b0;
        end else begin
            go_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (issue_ok_i) begin
                        state_q <= ST_ISSUE;
                        go_q    <= 1'b1;
                    end
                end
                ST_ISSUE: state_q <= ST_ARM;
                ST_ARM:   state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (mst_done_i) state_q <= ST_IDLE;
                end
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/avalon_tile_sched.sv
// Tile scheduler: splits one DATA_SIZE-word job into TILE_SIZE-word read/write tiles,
// bounds read-ahead by a tile credit and FIFO almost-full, and sequences both masters.
// Optional performance counters are built when AVALON_TILE_SCHED_PERF_EN is defined.
module avalon_tile_sched
    import avalon_sched_pkg::*;
#(
    parameter int XAW       = 32,
    parameter int DW        = 32,
    parameter int DATA_SIZE = 1024,
    parameter int TILE_SIZE = 128,
    parameter int MAX_AHEAD = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [XAW-1:0] src_base,
    input  logic [XAW-1:0] dst_base,
    output logic           busy,
    output logic           done,
`ifdef AVALON_TILE_SCHED_PERF_EN
    output logic [31:0]    perf_busy_cycles,
    output logic [31:0]    perf_stall_cycles,
`endif
    output logic           rmst_go,
    output logic [XAW-1:0] rmst_read_base,
    output logic [XAW-1:0] rmst_read_length,
    input  logic           rmst_done,
    input  logic           load_fifo_almost_full,
    output logic           wmst_go,
    output logic [XAW-1:0] wmst_write_base,
    output logic [XAW-1:0] wmst_write_length,
    input  logic           wmst_done
);

    localparam int TILE_BYTES = `AVS_TILE_BYTES(TILE_SIZE, DW);
    localparam int NUM_TILES  = `AVS_NUM_TILES(DATA_SIZE, TILE_SIZE);
    localparam int CW         = clog2(NUM_TILES + 1);

    localparam logic [CW-1:0]  NUM_C   = CW'(NUM_TILES);
    localparam logic [CW-1:0]  LAST_C  = CW'(NUM_TILES - 1);
    localparam logic [CW-1:0]  AHEAD_C = CW'(MAX_AHEAD);
    localparam logic [CW-1:0]  ONE_C   = CW'(1);
    localparam logic [XAW-1:0] TB_C    = XAW'(TILE_BYTES);

    logic [XAW-1:0] src_q, src_d, dst_q, dst_d;
    logic [XAW-1:0] rbase_q, rbase_d, rlen_q, rlen_d;
    logic [XAW-1:0] wbase_q, wbase_d, wlen_q, wlen_d;
    logic [CW-1:0]  rd_issued_q, rd_issued_d, rd_done_q, rd_done_d;
    logic [CW-1:0]  wr_issued_q, wr_done_q, wr_issued_d, wr_done_d;
    logic           busy_q, busy_d, done_q, done_d;

    logic [CW-1:0]  ahead;
    logic           start_acc;
    logic           rd_ok, rd_idle, rd_cmpl, rd_take;
    logic           wr_ok, wr_idle, wr_cmpl, wr_take;

    // Tiles read (done or in flight) but not yet written back.
    assign ahead     = rd_issued_q - wr_done_q;
    // A start in the final done cycle is dropped along with any start while busy.
    assign start_acc = start && !busy_q && !done_q;

    assign rd_ok = busy_q && (rd_issued_q < NUM_C) && (ahead < AHEAD_C)
                   && !load_fifo_almost_full && rmst_done;
    assign wr_ok = busy_q && (wr_issued_q < rd_done_q) && wmst_done;

    assign rd_take = rd_idle && rd_ok;
    assign wr_take = wr_idle && wr_ok;

    tile_issue_fsm u_rd_fsm (
        .clk        (clk),
        .rst        (rst),
        .issue_ok_i (rd_ok),
        .mst_done_i (rmst_done),
        .go_o       (rmst_go),
        .idle_o     (rd_idle),
        .complete_o (rd_cmpl)
    );

    tile_issue_fsm u_wr_fsm (
        .clk        (clk),
        .rst        (rst),
        .issue_ok_i (wr_ok),
        .mst_done_i (wmst_done),
        .go_o       (wmst_go),
        .idle_o     (wr_idle),
        .complete_o (wr_cmpl)
    );

    // Next-state for job control, tile counters and registered command fields.
    always_comb begin
        src_d       = src_q;
        dst_d       = dst_q;
        rbase_d     = rbase_q;
        rlen_d      = rlen_q;
        wbase_d     = wbase_q;
        wlen_d      = wlen_q;
        rd_issued_d = rd_issued_q;
        rd_done_d   = rd_done_q;
        wr_issued_d = wr_issued_q;
        wr_done_d   = wr_done_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        if (start_acc) begin
            src_d       = src_base;
            dst_d       = dst_base;
            rd_issued_d = '0;
            rd_done_d   = '0;
            wr_issued_d = '0;
            wr_done_d   = '0;
            busy_d      = 1'b1;
        end else begin
            if (rd_take) begin
                rbase_d     = src_q + XAW'(rd_issued_q) * TB_C;
                rlen_d      = TB_C;
                rd_issued_d = rd_issued_q + ONE_C;
            end
            if (rd_cmpl) rd_done_d = rd_done_q + ONE_C;
            if (wr_take) begin
                wbase_d     = dst_q + XAW'(wr_issued_q) * TB_C;
                wlen_d      = TB_C;
                wr_issued_d = wr_issued_q + ONE_C;
            end
            if (wr_cmpl) begin
                wr_done_d = wr_done_q + ONE_C;
                if (wr_done_q == LAST_C) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
        end
    end

    // State registers; reset aborts any job in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q       <= '0;
            dst_q       <= '0;
            rbase_q     <= '0;
            rlen_q      <= '0;
            wbase_q     <= '0;
            wlen_q      <= '0;
            rd_issued_q <= '0;
            rd_done_q   <= '0;
            wr_issued_q <= '0;
            wr_done_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            src_q       <= src_d;
            dst_q       <= dst_d;
            rbase_q     <= rbase_d;
            rlen_q      <= rlen_d;
            wbase_q     <= wbase_d;
            wlen_q      <= wlen_d;
            rd_issued_q <= rd_issued_d;
            rd_done_q   <= rd_done_d;
            wr_issued_q <= wr_issued_d;
            wr_done_q   <= wr_done_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign rmst_read_base    = rbase_q;
    assign rmst_read_length  = rlen_q;
    assign wmst_write_base   = wbase_q;
    assign wmst_write_length = wlen_q;

`ifdef AVALON_TILE_SCHED_PERF_EN
    logic [31:0] perf_busy_q, perf_stall_q;
    logic        stall;

    // Read side idle with work left but held back by credit or FIFO almost-full.
    assign stall = busy_q && rd_idle && (rd_issued_q < NUM_C)
                   && ((ahead >= AHEAD_C) || load_fifo_almost_full);

    // Saturating busy/stall cycle counters, cleared by each accepted start.
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (busy_q && (perf_busy_q != '1)) perf_busy_q <= perf_busy_q + 32'd1;
            if (stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_busy_cycles  = perf_busy_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: doc/avalon_tile_sched.md
# avalon_tile_sched

Tile scheduler for the Avalon read-master / write-master datapath.
- Splits one `DATA_SIZE`-word transfer into `TILE_SIZE`-word tiles.
- Issues `go`/base/length commands to the read master, which fills the shared load/store FIFO, and to the write master, which drains it.
- Limits read-ahead by a tile credit count and by FIFO almost-full.
- Sits between the configuration logic and the `mem_top` read/write control ports, and replaces ad-hoc `sig_delay` start sequencing.

## Interface
Parameters:
- `XAW`, 32: external address and length width.
- `DW`, 32: internal word width in bits.
- `DATA_SIZE`, 1024: total words per job. Must be a multiple of `TILE_SIZE`.
- `TILE_SIZE`, 128: words per tile.
- `MAX_AHEAD`, 2: maximum number of read tiles completed or in flight but not yet written. Range 1..(FIFO depth / `TILE_SIZE`).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: one-cycle job start pulse. Ignored while `busy`.
- `src_base` in XAW: read byte base. Sampled on `start`.
- `dst_base` in XAW: write byte base. Sampled on `start`.
- `busy` out 1: job in progress.
- `done` out 1: one-cycle pulse when the last write tile completes.
- `rmst_go` out 1: read command pulse.
- `rmst_read_base` out XAW: read tile byte address.
- `rmst_read_length` out XAW: read tile byte length.
- `rmst_done` in 1: read master idle (level).
- `load_fifo_almost_full` in 1: FIFO almost-full flag.
- `wmst_go` out 1: write command pulse.
- `wmst_write_base` out XAW: write tile byte address.
- `wmst_write_length` out XAW: write tile byte length.
- `wmst_done` in 1: write master idle (level).
- `perf_busy_cycles` out 32: present only with `AVALON_TILE_SCHED_PERF_EN`.
- `perf_stall_cycles` out 32: present only with `AVALON_TILE_SCHED_PERF_EN`.

## Operation
- Derived constants:
  - `TILE_BYTES = TILE_SIZE*DW/8`
  - `NUM_TILES = DATA_SIZE/TILE_SIZE`
  - Counters are `clog2(NUM_TILES+1)` bits wide.
- Accepted `start`:
  - latches both bases;
  - clears `rd_issued`, `rd_done_cnt` and `wr_done_cnt`;
  - sets `busy`.
- Read FSM states: `IDLE`, `ISSUE`, `ARM`, `WAIT`.
  - `IDLE -> ISSUE` when all hold: `busy`, `rd_issued < NUM_TILES`, `(rd_issued - wr_done_cnt) < MAX_AHEAD`, `!load_fifo_almost_full`, `rmst_done`.
  - `ISSUE`: `rmst_go=1` for exactly one cycle. Base = `src_base + rd_issued*TILE_BYTES`, truncated mod 2^XAW. Length = `TILE_BYTES`. `rd_issued++`.
  - `ARM`: one cycle in which `rmst_done` is ignored, covering the master's done-deassert latency.
  - `WAIT -> IDLE` on `rmst_done=1`, with `rd_done_cnt++`.
- Write FSM: same states.
  - Issue condition: `wr_issued < rd_done_cnt` and `wmst_done`.
  - Base = `dst_base + wr_issued*TILE_BYTES`.
  - Completion increments `wr_done_cnt`.
- Job end: when `wr_done_cnt` reaches `NUM_TILES`, pulse `done` for 1 cycle and clear `busy` in the same cycle.
- Simultaneous events:
  - Read and write completion in the same cycle update both counters.
  - The credit check uses registered counter values, so a credit freed this cycle is usable next cycle.
- `start` together with the final `done` cycle is ignored.

## Timing
- Reset values: all outputs 0; both FSMs `IDLE`; counters 0; perf counters 0.
- `rst` mid-job aborts immediately. No further `go` is issued. The bench must also reset the masters.
- Latency:
  - `start` to first `rmst_go`: 2 cycles (start latched, then `ISSUE`).
  - `rmst_done` rising in `WAIT` to a `wmst_go` for that tile: 2 cycles minimum.
- Base and length outputs are registered. They are valid in the `rmst_go`/`wmst_go` cycle and held until the next issue.
- `go` pulses are never back-to-back. Minimum 3 cycles between the `go` pulses of one FSM.

## Configuration
- `AVALON_TILE_SCHED_PERF_EN` defined:
  - `perf_busy_cycles` counts cycles with `busy=1`.
  - `perf_stall_cycles` counts `busy` cycles where the read FSM is `IDLE` with tiles remaining, blocked by credit or almost-full.
  - Both counters clear on accepted `start` and saturate at 2^32-1.
- Undefined: both ports and their counters are absent.

## Structure
- Shared package `avalon_sched_pkg`:
  - FSM state encoding (`ST_IDLE`, `ST_ISSUE`, `ST_ARM`, `ST_WAIT`, 2 bits);
  - `clog2` function;
  - the `TILE_BYTES`/`NUM_TILES` derivation macros.
- Sub-module `tile_issue_fsm`: generic issue/arm/wait FSM with an `issue_ok` input, the master `done` input, a `go` output and a `complete` pulse output. Instantiated twice, once for read and once for write. The top block holds the counters, address generation and credit logic.

## Test plan
All scenarios use defaults: `TILE_BYTES=512`, `NUM_TILES=8`.
- Basic job: `start` with `src_base=0x1000`, `dst_base=0x8000`, zero-delay masters.
  - Response: 8 `rmst_go` with bases 0x1000, 0x1200 … 0x1E00.
  - Response: 8 `wmst_go` with bases 0x8000 … 0x8E00.
  - Response: all lengths 512; single `done`; `busy` falls with `done`.
- Credit limit: write master stalls with `wmst_done=0` for 200 cycles.
  - Response: exactly 2 reads complete, 3rd `rmst_go` absent until first write completes.
- Almost-full: hold `load_fifo_almost_full=1` for 50 cycles after first read.
  - Response: no `rmst_go` during the hold; resumes 1 cycle after release.
  - Response with `AVALON_TILE_SCHED_PERF_EN`: `perf_stall_cycles` ≥ 50.
- Address wrap: `src_base=0xFFFFFE00`.
  - Response: second `rmst_read_base=0x00000000`.
- Abort/restart: `rst` after 3rd `rmst_go`.
  - Response: all outputs 0 next cycle.
  - Response: new `start` runs a full 8-tile job from the new bases.
- `start` while `busy`: 2nd pulse mid-job.
  - Response: ignored, bases unchanged, exactly one `done`.
